qcldpc_syndrome_check: RTL and testbench

Receive-side counterpart of the QC-LDPC encoder controller. It accepts one received hard-decision codeword as Z-bit circulant blocks, info blocks first and then parity blocks. It computes the syndrome H·cᵀ over GF(2) column by column from the same prototype-matrix shift ROM contents the encoder uses. At the end of each codeword it reports a pass/fail flag and, optionally, the full syndrome, to the downstream decoder/scheduler.

---
 rtl/qcldpc_pkg.sv | 55 +++++
 rtl/qcldpc_circ_rotate.sv | 38 +++
 rtl/qcldpc_syndrome_check.sv | 177 +++++++++++++++++
 tb/tb_qcldpc_syndrome_check.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcldpc_pkg.sv
// +-------------------------------------------------------------------------+
// | qcldpc_pkg : shared constants, state encoding and helpers for QC-LDPC    |
// | Revision   : 1.0                                                         |
// +-------------------------------------------------------------------------+
`default_nettype none

package qcldpc_pkg;

   localparam int unsigned MAX_Z     = 81;
   localparam int unsigned SHW       = $clog2(MAX_Z);
   localparam int unsigned NUM_Z_DEF = 3;
   localparam int unsigned Z_VALUE_ARRAY_DEF [NUM_Z_DEF] = '{27, 54, 81};

   // Wide enough to cover any practical shift width; users slice the low bits.
   localparam logic [31:0] SHIFT_NULL = '1;
   localparam int unsigned ZMASK_W    = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2,
      ST_DROP  = 2'd3
   } state_e;

   typedef struct packed {
      logic       valid;
      logic [7:0] idx;
   } zsel_t;

   function automatic zsel_t onehot_to_zidx(input logic [31:0] onehot, input int unsigned n);
      zsel_t       r;
      int unsigned cnt;
      r   = '0;
      cnt = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < n && onehot[i]) begin
            cnt   = cnt + 1;
            r.idx = 8'(i);
         end
      end
      r.valid = (cnt == 1);
      if (!r.valid) r.idx = '0;
      return r;
   endfunction

   function automatic logic [ZMASK_W-1:0] zmask(input int unsigned z);
      logic [ZMASK_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < ZMASK_W; i++) m[i] = (i < z);
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/qcldpc_circ_rotate.sv
// +-------------------------------------------------------------------------+
// | qcldpc_circ_rotate : Z-bit cyclic rotate, out[i] = in[(i+s) mod Z]      |
// | Revision           : 1.0                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module qcldpc_circ_rotate
   import qcldpc_pkg::*;
#(
   parameter int unsigned MAX_Z = 81,
   parameter int unsigned SHW   = 7
) (
   input  logic [MAX_Z-1:0] i_data,
   input  logic [SHW-1:0]   i_z,
   input  logic [SHW-1:0]   i_shift,
   output logic [MAX_Z-1:0] o_data
);

   logic [MAX_Z-1:0] w_mask;
   logic [MAX_Z-1:0] w_din;
   logic [SHW-1:0]   w_s_eff;

   assign w_mask = MAX_Z'(zmask(32'(i_z)));
   assign w_din  = i_data & w_mask;

   // Right shift supplies in[i+s]; left shift by Z-s wraps the low bits back in.
   always_comb begin
      w_s_eff = '0;
      o_data  = '0;
      if (i_z != '0 && i_shift != SHIFT_NULL[SHW-1:0]) begin
         w_s_eff = (i_shift >= i_z) ? (i_shift % i_z) : i_shift;
         o_data  = ((w_din >> w_s_eff) | (w_din << (i_z - w_s_eff))) & w_mask;
      end
   end

endmodule

`default_nettype wire

// File: rtl/qcldpc_syndrome_check.sv
// +-------------------------------------------------------------------------+
// | qcldpc_syndrome_check : column-serial GF(2) syndrome of a QC-LDPC word   |
// | Option macro QCLDPC_SYND_OUT_EN adds the registered syndrome port.       |
// | Revision              : 1.0                                              |
// +-------------------------------------------------------------------------+
`default_nettype none

module qcldpc_syndrome_check
   import qcldpc_pkg::*;
#(
   parameter int unsigned NUM_OF_SUPPORTED_Z           = 3,
   parameter int unsigned HIGHEST_SUPPORTED_Z_VAL      = 81,
   parameter int unsigned NUM_INFO_BLKS_PER_CODE_BLK   = 20,
   parameter int unsigned NUM_PARITY_BLKS_PER_CODE_BLK = 4,
   parameter int unsigned Z_VALUE_ARRAY [NUM_OF_SUPPORTED_Z] = Z_VALUE_ARRAY_DEF
) (
   input  logic                                    CLK,
   input  logic                                    rst,
   input  logic [NUM_OF_SUPPORTED_Z-1:0]           req_z,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [HIGHEST_SUPPORTED_Z_VAL-1:0]      in_data,
   output logic [$clog2((NUM_INFO_BLKS_PER_CODE_BLK+NUM_PARITY_BLKS_PER_CODE_BLK)*NUM_OF_SUPPORTED_Z)-1:0] rom_addr,
   input  logic [NUM_PARITY_BLKS_PER_CODE_BLK*$clog2(HIGHEST_SUPPORTED_Z_VAL)-1:0] rom_shift,
   output logic                                    synd_valid,
   output logic                                    synd_ok,
   output logic                                    z_err
`ifdef QCLDPC_SYND_OUT_EN
   ,output logic [NUM_PARITY_BLKS_PER_CODE_BLK*HIGHEST_SUPPORTED_Z_VAL-1:0] syndrome
`endif
);

   localparam int unsigned ZSN    = NUM_OF_SUPPORTED_Z;
   localparam int unsigned MZ     = HIGHEST_SUPPORTED_Z_VAL;
   localparam int unsigned NPB    = NUM_PARITY_BLKS_PER_CODE_BLK;
   localparam int unsigned NCOLS  = NUM_INFO_BLKS_PER_CODE_BLK + NPB;
   localparam int unsigned SHW_L  = $clog2(MZ);
   localparam int unsigned ADDR_W = $clog2(NCOLS * ZSN);
   localparam int unsigned COL_W  = $clog2(NCOLS);
   localparam int unsigned ZIDX_W = (ZSN > 1) ? $clog2(ZSN) : 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NCOLS - 1);

   state_e              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ZIDX_W-1:0]   zidx_q, zidx_d;
   logic [SHW_L-1:0]    z_q, z_d;
   logic [NPB*MZ-1:0]   acc_q, acc_d;
   logic                z_err_q, z_err_d;

   zsel_t               live_sel;
   logic                live_ok;
   logic [ZIDX_W-1:0]   live_zidx;
   logic [SHW_L-1:0]    live_z;
   logic [ZIDX_W-1:0]   cur_zidx;
   logic [SHW_L-1:0]    cur_z;
   logic [NPB*MZ-1:0]   rot_all;

   always_comb begin
      live_sel  = onehot_to_zidx(32'(req_z), ZSN);
      live_ok   = live_sel.valid;
      live_zidx = ZIDX_W'(live_sel.idx);
      live_z    = SHW_L'(Z_VALUE_ARRAY[live_zidx]);
   end

   // IDLE processes column 0 before zidx/Z are latched, so it uses the live select.
   assign cur_zidx = (state_q == ST_IDLE) ? live_zidx : zidx_q;
   assign cur_z    = (state_q == ST_IDLE) ? live_z    : z_q;
   assign rom_addr = ADDR_W'(32'(cur_zidx) * NCOLS + 32'(col_q));

   for (genvar r = 0; r < NPB; r++) begin : g_row
      qcldpc_circ_rotate #(
         .MAX_Z (MZ),
         .SHW   (SHW_L)
      ) u_rot (
         .i_data  (in_data),
         .i_z     (cur_z),
         .i_shift (rom_shift[r*SHW_L +: SHW_L]),
         .o_data  (rot_all[r*MZ +: MZ])
      );
   end

`ifdef QCLDPC_SYND_OUT_EN
   logic [NPB*MZ-1:0] syndrome_q, syndrome_d;
   assign syndrome = syndrome_q;
`endif

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      zidx_d     = zidx_q;
      z_d        = z_q;
      acc_d      = acc_q;
      z_err_d    = 1'b0;
      in_ready   = 1'b1;
      synd_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            acc_d = '0;
            if (in_valid) begin
               col_d = COL_W'(1);
               if (live_ok) begin
                  zidx_d  = live_zidx;
                  z_d     = live_z;
                  acc_d   = rot_all;
                  state_d = ST_ACCUM;
               end else begin
                  z_err_d = 1'b1;
                  state_d = ST_DROP;
               end
            end
         end
         ST_ACCUM: begin
            if (in_valid) begin
               acc_d = acc_q ^ rot_all;
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         ST_DONE: begin
            in_ready   = 1'b0;
            synd_valid = 1'b1;
            acc_d      = '0;
            state_d    = ST_IDLE;
         end
         ST_DROP: begin
            if (in_valid) begin
               if (col_q == LAST_COL) begin
                  col_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef QCLDPC_SYND_OUT_EN
      // Capture on the final beat so the register is already valid in DONE.
      syndrome_d = syndrome_q;
      if (state_q == ST_ACCUM && in_valid && col_q == LAST_COL) syndrome_d = acc_d;
`endif
   end

   assign synd_ok = synd_valid && (acc_q == '0);
   assign z_err   = z_err_q;

   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         col_q      <= '0;
         zidx_q     <= '0;
         z_q        <= '0;
         acc_q      <= '0;
         z_err_q    <= 1'b0;
`ifdef QCLDPC_SYND_OUT_EN
         syndrome_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         zidx_q     <= zidx_d;
         z_q        <= z_d;
         acc_q      <= acc_d;
         z_err_q    <= z_err_d;
`ifdef QCLDPC_SYND_OUT_EN
         syndrome_q <= syndrome_d;
`endif
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_qcldpc_syndrome_check.sv
// +-------------------------------------------------------------------------+
// | tb_qcldpc_syndrome_check : scoreboard bench for qcldpc_syndrome_check    |
// | Revision                 : 1.0                                           |
// +-------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_qcldpc_syndrome_check;

   localparam int MZ  = 81;
   localparam int NPB = 4;
   localparam int NIB = 20;
   localparam int NC  = 24;
   localparam int SW  = 7;
   localparam int ZSN = 3;
   localparam int ZV [ZSN] = '{27, 54, 81};

   typedef logic [MZ-1:0]     blk_t;
   typedef logic [NPB*MZ-1:0] syn_t;
   typedef struct packed {
      logic ok;
      syn_t syn;
   } exp_t;

   logic              CLK = 1'b0;
   logic              rst = 1'b1;
   logic [ZSN-1:0]    req_z = 3'b001;
   logic              in_valid = 1'b0;
   logic              in_ready;
   blk_t              in_data = '0;
   logic [6:0]        rom_addr;
   logic [NPB*SW-1:0] rom_shift;
   logic              synd_valid;
   logic              synd_ok;
   logic              z_err;
`ifdef QCLDPC_SYND_OUT_EN
   syn_t              syndrome;
`endif

   qcldpc_syndrome_check dut (
      .CLK        (CLK),
      .rst        (rst),
      .req_z      (req_z),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .rom_addr   (rom_addr),
      .rom_shift  (rom_shift),
      .synd_valid (synd_valid),
      .synd_ok    (synd_ok),
      .z_err      (z_err)
`ifdef QCLDPC_SYND_OUT_EN
      ,.syndrome  (syndrome)
`endif
   );

   always #5 CLK = ~CLK;

   // Info columns get pseudo-random shifts with some nulls; parity column 20+r
   // is the identity in row r only, so parity = XOR of rotated info blocks.
   function automatic logic [6:0] shift_of(int zi, int col, int r);
      if (col >= NIB) return (col - NIB == r) ? 7'd0 : 7'h7f;
      if ((col * 3 + r * 5) % 7 == 5) return 7'h7f;
      return 7'((col * 11 + r * 17 + zi * 5 + 3) % ZV[zi]);
   endfunction

   function automatic logic [NPB*SW-1:0] rom_model(logic [6:0] a);
      int zi;
      int col;
      logic [NPB*SW-1:0] v;
      zi  = int'(a) / NC;
      col = int'(a) % NC;
      if (zi >= ZSN) zi = 0;
      for (int r = 0; r < NPB; r++) v[r*SW +: SW] = shift_of(zi, col, r);
      return v;
   endfunction

   assign rom_shift = rom_model(rom_addr);

   function automatic blk_t rot(blk_t d, int s, int z);
      blk_t o;
      o = '0;
      if (s == 127) return o;
      for (int i = 0; i < z; i++) o[i] = d[(i + s) % z];
      return o;
   endfunction

   blk_t fr [NC];

   function automatic syn_t model_synd(int zi);
      syn_t s;
      s = '0;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NPB; r++)
            s[r*MZ +: MZ] = s[r*MZ +: MZ] ^ rot(fr[c], int'(shift_of(zi, c, r)), ZV[zi]);
      return s;
   endfunction

   function automatic blk_t rand_blk();
      return blk_t'({$urandom(), $urandom(), $urandom()});
   endfunction

   task automatic fill_random();
      for (int c = 0; c < NC; c++) fr[c] = rand_blk();
   endtask

   task automatic encode(int zi);
      blk_t p;
      for (int c = 0; c < NIB; c++) fr[c] = rand_blk();
      for (int r = 0; r < NPB; r++) begin
         p = '0;
         for (int c = 0; c < NIB; c++) p = p ^ rot(fr[c], int'(shift_of(zi, c, r)), ZV[zi]);
         fr[NIB + r] = p;
      end
   endtask

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input syn_t got, input syn_t exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   exp_t sb [$];
   int   z_err_cnt = 0;
   int   rdy_bad   = 0;
   int   valid_cnt = 0;

   always @(negedge CLK) begin
      exp_t e;
      if (!rst) begin
         if (z_err) z_err_cnt++;
         if (!in_ready && !synd_valid) rdy_bad++;
         if (synd_valid) begin
            valid_cnt++;
            if (sb.size() == 0) begin
               check("unexpected_synd_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("synd_ok", syn_t'(synd_ok), syn_t'(e.ok));
`ifdef QCLDPC_SYND_OUT_EN
               check("syndrome", syndrome, e.syn);
`endif
            end
         end
      end
   end

   task automatic beat(input blk_t d, input logic [ZSN-1:0] z);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = d;
      req_z    = z;
      while (!in_ready && guard < 10) begin
         @(posedge CLK); #1;
         guard++;
      end
      if (!in_ready) check("ready_timeout", syn_t'(in_ready), 1);
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   // gaps: idle cycles between beats and junk req_z after the first beat
   task automatic send_frame(input logic [ZSN-1:0] z, input int gaps, input int nbeats,
                             input int expect_done);
      logic [6:0] a;
      for (int c = 0; c < nbeats; c++) begin
         beat(fr[c], (c == 0 || gaps == 0) ? z : ZSN'($urandom_range(0, 7)));
         if (gaps != 0 && c < nbeats - 1 && $urandom_range(0, 1) == 1) begin
            a = rom_addr;
            repeat ($urandom_range(1, 3)) begin
               @(posedge CLK); #1;
            end
            check("col_hold_in_gap", syn_t'(rom_addr), syn_t'(a));
         end
      end
      if (expect_done != 0) begin
         check("done_latency_valid", syn_t'(synd_valid), 1);
         check("done_in_ready_low", syn_t'(in_ready), 0);
      end
   endtask

   task automatic push(input logic ok, input syn_t s);
      exp_t e;
      e.ok  = ok;
      e.syn = s;
      sb.push_back(e);
   endtask

   initial begin
      syn_t s;
      syn_t e_syn;
      int   sh;

      repeat (3) @(posedge CLK);
      #1 rst = 1'b0;
      check("rst_in_ready", syn_t'(in_ready), 1);
      check("rst_synd_valid", syn_t'(synd_valid), 0);
      check("rst_synd_ok", syn_t'(synd_ok), 0);
      check("rst_z_err", syn_t'(z_err), 0);
`ifdef QCLDPC_SYND_OUT_EN
      check("rst_syndrome", syndrome, '0);
`endif

      // Z=81 all-zero codeword
      for (int c = 0; c < NC; c++) fr[c] = '0;
      send_frame(3'b100, 0, NC, 1);
      push(1'b1, '0);

      // Z=27 encoded codeword, then the same with bit 5 of column 0 flipped
      encode(0);
      send_frame(3'b001, 0, NC, 1);
      push(1'b1, '0);
      fr[0][5] = ~fr[0][5];
      e_syn = '0;
      for (int r = 0; r < NPB; r++) begin
         sh = int'(shift_of(0, 0, r));
         if (sh != 127) e_syn[r*MZ + ((5 - sh + 27) % 27)] = 1'b1;
      end
      send_frame(3'b001, 0, NC, 1);
      push(1'b0, e_syn);

      // Z=54: codeword without and with gaps, then random data with gaps
      encode(1);
      send_frame(3'b010, 0, NC, 1);
      push(1'b1, '0);
      send_frame(3'b010, 1, NC, 1);
      push(1'b1, '0);
      fill_random();
      s = model_synd(1);
      send_frame(3'b010, 1, NC, 1);
      push(s == '0, s);

      // non-one-hot req_z: frame dropped, then a valid Z=27 frame
      fill_random();
      send_frame(3'b011, 0, NC, 0);
      check("drop_no_valid", syn_t'(synd_valid), 0);
      req_z = 3'b010;
      #1;
      check("drop_back_to_idle_addr", syn_t'(rom_addr), 24);
      check("drop_z_err_count", syn_t'(z_err_cnt), 1);
      fill_random();
      s = model_synd(0);
      send_frame(3'b001, 0, NC, 1);
      push(s == '0, s);

      // reset after beat 10, then a fresh Z=81 frame
      encode(2);
      send_frame(3'b100, 0, 10, 0);
      rst = 1'b1;
      @(posedge CLK); #1;
      rst = 1'b0;
      check("midrst_in_ready", syn_t'(in_ready), 1);
      check("midrst_col_zero", syn_t'(rom_addr), 48);
      fill_random();
      s = model_synd(2);
      send_frame(3'b100, 0, NC, 1);
      push(s == '0, s);

      // two consecutive Z=81 frames
      fill_random();
      s = model_synd(2);
      send_frame(3'b100, 0, NC, 1);
      push(s == '0, s);
      encode(2);
      send_frame(3'b100, 0, NC, 1);
      push(1'b1, '0);

      repeat (4) @(posedge CLK);
      #1;
      check("scoreboard_drained", syn_t'(sb.size()), 0);
      check("ready_low_only_in_done", syn_t'(rdy_bad), 0);
      check("synd_valid_count", syn_t'(valid_cnt), 10);
      check("z_err_total", syn_t'(z_err_cnt), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
